plane_inlier_scorer: RTL

Multi-lane, pipelined successor to the single-point inlier check. It accepts a frame of points `LANES` at a time and tests each against one latched plane (unit normal `n`, offset `d`, threshold `t`). It accumulates the number of inliers and returns that count as the RANSAC hypothesis score. It sits between the point-cloud streamer and the hypothesis-selection logic.

---
 rtl/plane_inlier_scorer_pkg.sv | 38 +++
 rtl/plane_distance_lane.sv | 85 ++++++++
 rtl/plane_inlier_scorer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/plane_inlier_scorer_pkg.sv
// Shared fixed-point vector types for the plane inlier scorer.
// Holds the single/double precision fixed-point types, the 3-vector
// struct, the extended accumulation type (double plus two guard bits),
// the widening helper used to align single values to double precision,
// and the scorer FSM state encoding.
package plane_inlier_scorer_pkg;

    localparam int SINGLE_W     = 32;
    localparam int single_fbits = 16;
    localparam int DOUBLE_W     = 2 * SINGLE_W;
    localparam int double_fbits = 2 * single_fbits;
    localparam int EXT_W        = DOUBLE_W + 2;

    typedef logic signed [SINGLE_W-1:0] single_t;
    typedef logic signed [DOUBLE_W-1:0] double_t;
    typedef logic signed [EXT_W-1:0]    extended_t;

    typedef struct packed {
        single_t x;
        single_t y;
        single_t z;
    } vector3s_s;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Sign-extend a single value and move its binary point to double_fbits.
    function automatic extended_t widen_single(input single_t v);
        extended_t w;
        w = extended_t'(v);
        return w << single_fbits;
    endfunction

endpackage

// File: rtl/plane_distance_lane.sv
// One lane of the plane distance test (stages S1..S3).
// S1 forms the three exact double-precision products, S2 sums them with
// guard bits and subtracts the widened offset, S3 takes |s| and compares
// against the widened threshold. A valid bit travels alongside the data.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-low reset
//   i_valid, i_mask    beat accepted / this lane's point is present
//   i_p, i_n           point and latched plane normal
//   i_d_ext, i_t_ext   offset and threshold already widened to extended_t
//   o_valid, o_inlier  S3 result valid / lane is an inlier
//   o_busy             any stage of this lane holds a valid beat
module plane_distance_lane
    import plane_inlier_scorer_pkg::*;
(
    input  logic      i_clock,
    input  logic      i_reset,
    input  logic      i_valid,
    input  logic      i_mask,
    input  vector3s_s i_p,
    input  vector3s_s i_n,
    input  extended_t i_d_ext,
    input  extended_t i_t_ext,
    output logic      o_valid,
    output logic      o_inlier,
    output logic      o_busy
);

    double_t   r_prod_x;
    double_t   r_prod_y;
    double_t   r_prod_z;
    extended_t r_s;
    extended_t w_abs_s;
    logic      r_valid_1;
    logic      r_valid_2;
    logic      r_valid_3;
    logic      r_mask_1;
    logic      r_mask_2;
    logic      r_inlier;

    // Absolute value of the signed distance; guard bits make negation safe.
    always_comb begin
        w_abs_s = r_s;
        if (r_s[EXT_W-1]) begin
            w_abs_s = -r_s;
        end else begin
            w_abs_s = r_s;
        end
    end

    // Three-stage datapath: multiply, sum/subtract, compare.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_prod_x  <= '0;
            r_prod_y  <= '0;
            r_prod_z  <= '0;
            r_s       <= '0;
            r_valid_1 <= 1'b0;
            r_valid_2 <= 1'b0;
            r_valid_3 <= 1'b0;
            r_mask_1  <= 1'b0;
            r_mask_2  <= 1'b0;
            r_inlier  <= 1'b0;
        end else begin
            // Mask is qualified by valid so idle cycles never look like inliers.
            r_valid_1 <= i_valid;
            r_mask_1  <= i_valid & i_mask;
            r_prod_x  <= double_t'(i_n.x) * double_t'(i_p.x);
            r_prod_y  <= double_t'(i_n.y) * double_t'(i_p.y);
            r_prod_z  <= double_t'(i_n.z) * double_t'(i_p.z);

            r_valid_2 <= r_valid_1;
            r_mask_2  <= r_mask_1;
            r_s       <= extended_t'(r_prod_x) + extended_t'(r_prod_y)
                       + extended_t'(r_prod_z) - i_d_ext;

            r_valid_3 <= r_valid_2;
            r_inlier  <= r_mask_2 && (w_abs_s <= i_t_ext);
        end
    end

    assign o_valid  = r_valid_3;
    assign o_inlier = r_inlier;
    assign o_busy   = r_valid_1 | r_valid_2 | r_valid_3;

endmodule

// File: rtl/plane_inlier_scorer.sv
// RANSAC plane hypothesis scorer: streams LANES points per beat through a
// four-stage pipeline and counts the points within distance t of the
// latched plane (n, d). The saturating count is returned as the score.
// Ports:
//   clock, reset          clock, asynchronous active-low reset
//   start, n, d, t        begin a frame and latch the plane (IDLE only)
//   ivalid/iready         beat handshake; p, imask, ilast carry the beat
//   ovalid/oacknowledge   score handshake; score is the frame inlier count
module plane_inlier_scorer
    import plane_inlier_scorer_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int COUNT_BITS = 32
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  vector3s_s               n,
    input  single_t                 d,
    input  single_t                 t,
    input  logic                    ivalid,
    output logic                    iready,
    input  vector3s_s [LANES-1:0]   p,
    input  logic [LANES-1:0]        imask,
    input  logic                    ilast,
    output logic                    ovalid,
    input  logic                    oacknowledge,
    output logic [COUNT_BITS-1:0]   score
);

    localparam int POP_W = $clog2(LANES + 1);
    localparam int SUM_W = ((COUNT_BITS > POP_W) ? COUNT_BITS : POP_W) + 1;
    localparam logic [SUM_W-1:0] COUNT_MAX = SUM_W'({COUNT_BITS{1'b1}});

    state_e                r_state;
    state_e                w_next_state;
    vector3s_s             r_n;
    single_t               r_d;
    single_t               r_t;
    extended_t             w_d_ext;
    extended_t             w_t_ext;
    logic [COUNT_BITS-1:0] r_count;
    logic [COUNT_BITS-1:0] w_count_next;
    logic [SUM_W-1:0]      w_sum;
    logic [POP_W-1:0]      w_pop;
    logic                  r_iready;
    logic                  r_ovalid;
    logic                  w_accept;
    logic                  w_frame_start;
    logic                  w_beat_done;
    logic [LANES-1:0]      w_lane_valid;
    logic [LANES-1:0]      w_lane_inlier;
    logic [LANES-1:0]      w_lane_busy;

    assign w_accept      = ivalid & r_iready;
    assign w_frame_start = (r_state == ST_IDLE) & start;
    assign w_beat_done   = |w_lane_valid;
    assign w_d_ext       = widen_single(r_d);
    assign w_t_ext       = widen_single(r_t);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        plane_distance_lane u_lane (
            .i_clock  (clock),
            .i_reset  (reset),
            .i_valid  (w_accept),
            .i_mask   (imask[g]),
            .i_p      (p[g]),
            .i_n      (r_n),
            .i_d_ext  (w_d_ext),
            .i_t_ext  (w_t_ext),
            .o_valid  (w_lane_valid[g]),
            .o_inlier (w_lane_inlier[g]),
            .o_busy   (w_lane_busy[g])
        );
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
                else       w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (w_accept && ilast) w_next_state = ST_DRAIN;
                else                   w_next_state = ST_RUN;
            end
            ST_DRAIN: begin
                if (!(|w_lane_busy)) w_next_state = ST_DONE;
                else                 w_next_state = ST_DRAIN;
            end
            ST_DONE: begin
                if (oacknowledge) w_next_state = ST_IDLE;
                else              w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // S4 popcount of this beat's inlier lanes and saturating add to the count.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + POP_W'(w_lane_inlier[i]);
        end
        w_sum = SUM_W'(r_count) + SUM_W'(w_pop);
        if (w_sum > COUNT_MAX) begin
            w_count_next = {COUNT_BITS{1'b1}};
        end else begin
            w_count_next = w_sum[COUNT_BITS-1:0];
        end
    end

    // State, registered handshake outputs, plane latch and inlier count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_iready <= 1'b0;
            r_ovalid <= 1'b0;
            r_n      <= '0;
            r_d      <= '0;
            r_t      <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_iready <= (w_next_state == ST_RUN);
            r_ovalid <= (w_next_state == ST_DONE);
            if (w_frame_start) begin
                r_n <= n;
                r_d <= d;
                r_t <= t;
            end else begin
                r_n <= r_n;
                r_d <= r_d;
                r_t <= r_t;
            end
            if (w_frame_start) begin
                r_count <= '0;
            end else if (w_beat_done) begin
                r_count <= w_count_next;
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign iready = r_iready;
    assign ovalid = r_ovalid;
    assign score  = r_count;

endmodule
